// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a one-cycle read response and a built-in
// signed-max scan over a fixed window of words.
module data_mem_responder #(
  parameter int DEPTH     = 1024,
  parameter int SCAN_BASE = 250,
  parameter int SCAN_LEN  = 20
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  input  logic        scan_start,
  output logic        scan_busy,
  output logic        scan_done,
  output logic [31:0] max,
  output logic [31:0] max_index
);

  // DEPTH is assumed to be a power of two so the address slice wraps cleanly.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SCAN_LEN + 1);
  localparam logic [AW-1:0] SCAN_FIRST = AW'(SCAN_BASE % DEPTH);
  localparam logic [AW-1:0] WORD_LAST  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] ELEM_LAST  = CW'(SCAN_LEN - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [AW-1:0] scan_ptr_reg;
  logic [31:0]   run_max_reg;
  logic [31:0]   run_idx_reg;

  logic [AW-1:0] word_idx;
  logic          accept;
  logic          wr_en;
  logic [31:0]   elem;
  logic          take;
  logic [31:0]   cand_max;
  logic [31:0]   cand_idx;
  logic          unused_addr_bits;

  logic [31:0] mem [DEPTH];

  assign word_idx         = req_addr[AW+1:2];
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign accept           = req_valid && req_ready;
  assign wr_en            = accept && req_write;

  // Each word is its own register so that reset can clear the whole memory in one edge.
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [31:0] word_reg;
    always_ff @(posedge clock) begin
      if (!rst) begin
        word_reg <= '0;
      end else if (wr_en && (word_idx == AW'(gi))) begin
        word_reg <= req_wdata;
      end
    end
    assign mem[gi] = word_reg;
  end

  // Element 0 seeds the running max; later elements must be strictly greater.
  assign elem     = mem[scan_ptr_reg];
  assign take     = (cnt_reg == '0) || ($signed(elem) > $signed(run_max_reg));
  assign cand_max = take ? elem : run_max_reg;
  assign cand_idx = take ? 32'(cnt_reg) : run_idx_reg;

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    scan_busy  = 1'b0;
    scan_done  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (scan_start) state_next = SCAN;
      end
      SCAN: begin
        scan_busy = 1'b1;
        if (cnt_reg == ELEM_LAST) state_next = DONE;
      end
      DONE: begin
        scan_busy  = 1'b1;
        scan_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      scan_ptr_reg <= SCAN_FIRST;
      run_max_reg  <= '0;
      run_idx_reg  <= '0;
      max          <= '0;
      max_index    <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      state_reg <= state_next;
      rsp_valid <= accept && !req_write;
      if (accept && !req_write) rsp_rdata <= mem[word_idx];

      if (state_reg == IDLE) begin
        cnt_reg      <= '0;
        scan_ptr_reg <= SCAN_FIRST;
      end else if (state_reg == SCAN) begin
        cnt_reg      <= cnt_reg + 1'b1;
        scan_ptr_reg <= (scan_ptr_reg == WORD_LAST) ? '0 : scan_ptr_reg + 1'b1;
        run_max_reg  <= cand_max;
        run_idx_reg  <= cand_idx;
        // Published result changes only on the edge that enters DONE.
        if (cnt_reg == ELEM_LAST) begin
          max       <= cand_max;
          max_index <= cand_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a cycle-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_data_mem_responder;

  localparam int DEPTH     = 1024;
  localparam int SCAN_BASE = 250;
  localparam int SCAN_LEN  = 20;

  logic        clock = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        scan_start;
  logic        scan_busy;
  logic        scan_done;
  logic [31:0] max;
  logic [31:0] max_index;

  int n_vec = 0;
  int n_bad = 0;

  data_mem_responder #(
    .DEPTH(DEPTH), .SCAN_BASE(SCAN_BASE), .SCAN_LEN(SCAN_LEN)
  ) dut (
    .clock(clock), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
    .max(max), .max_index(max_index)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, pending response, and the number of
  // busy cycles still ahead (SCAN_LEN scan cycles plus one done cycle).
  logic [31:0] m_mem [DEPTH];
  int          remain = 0;
  logic        e_rsp_valid = 1'b0;
  logic [31:0] e_rdata = '0;
  logic [31:0] e_max = '0;
  logic [31:0] e_idx = '0;
  logic [31:0] p_max = '0;
  logic [31:0] p_idx = '0;
  bit          primed = 1'b0;

  task automatic model_scan();
    logic [31:0] v;
    p_max = m_mem[SCAN_BASE % DEPTH];
    p_idx = 0;
    for (int i = 1; i < SCAN_LEN; i++) begin
      v = m_mem[(SCAN_BASE + i) % DEPTH];
      if ($signed(v) > $signed(p_max)) begin
        p_max = v;
        p_idx = 32'(i);
      end
    end
  endtask

  initial begin
    int w;
    forever begin
      @(negedge clock);
      if (primed) begin
        chkb("req_ready", req_ready, remain == 0);
        chkb("scan_busy", scan_busy, remain != 0);
        chkb("scan_done", scan_done, remain == 1);
        chkb("rsp_valid", rsp_valid, e_rsp_valid);
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("max", max, e_max);
        chk("max_index", max_index, e_idx);
      end
      if (rst === 1'b0) begin
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
        remain = 0; e_rsp_valid = 1'b0; e_rdata = '0; e_max = '0; e_idx = '0;
        primed = 1'b1;
      end else if (primed) begin
        e_rsp_valid = 1'b0;
        if (remain > 0) begin
          remain--;
          if (remain == 1) begin
            e_max = p_max;
            e_idx = p_idx;
          end
        end else begin
          if (req_valid) begin
            w = int'((req_addr >> 2) % DEPTH);
            if (req_write) m_mem[w] = req_wdata;
            else begin
              e_rsp_valid = 1'b1;
              e_rdata = m_mem[w];
            end
          end
          if (scan_start) begin
            model_scan();
            remain = SCAN_LEN + 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; scan_start = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    $display("write addr=%0d data=%h", a, d);
    step();
    idle_inputs();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    step();
    idle_inputs();
    chkb("read_rsp_valid", rsp_valid, 1'b1);
    d = rsp_rdata;
    $display("read  addr=%0d data=%h", a, d);
  endtask

  // Pulses scan_start (optionally with a write to element 0 on the same edge),
  // pokes requests mid-scan, and checks latency, ready and the result.
  task automatic run_scan(input string tag, input logic [31:0] xmax, input logic [31:0] xidx,
                          input bit with_wr0, input logic [31:0] wr0_data);
    int lat;
    lat = 0;
    scan_start = 1'b1;
    if (with_wr0) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd1000; req_wdata = wr0_data;
    end
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      step();
      idle_inputs();
      chkb({tag, "_ready_low"}, req_ready, 1'b0);
      if (scan_done) lat = k;
      if (k == 3) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd1060; req_wdata = 32'hDEAD_BEEF;
      end
      if (k == 4) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd1060;
      end
    end
    idle_inputs();
    chk({tag, "_latency"}, 32'(lat), 32'd21);
    chk({tag, "_max"}, max, xmax);
    chk({tag, "_index"}, max_index, xidx);
    $display("scan  %s max=%h index=%0d latency=%0d", tag, max, max_index, lat);
    step();
    chkb({tag, "_ready_back"}, req_ready, 1'b1);
    chkb({tag, "_done_once"}, scan_done, 1'b0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] v;
    int dones;
    rst = 1'b0;
    idle_inputs();
    step();
    step();
    rst = 1'b1;
    chkb("reset_ready", req_ready, 1'b1);
    chkb("reset_busy", scan_busy, 1'b0);
    chk("reset_max", max, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);

    do_write(32'd1004, 32'h0000_00AB);
    do_read(32'd1004, d);
    chk("read_after_write", d, 32'h0000_00AB);
    do_read(32'd1004 + 32'(4 * DEPTH), d);
    chk("read_wrap", d, 32'h0000_00AB);
    do_read(32'd1007, d);
    chk("read_unaligned", d, 32'h0000_00AB);
    do_read(32'h8000_03EC, d);
    chk("read_high_bits", d, 32'h0000_00AB);
    step();
    chkb("rsp_single_cycle", rsp_valid, 1'b0);
    chk("rdata_held", rsp_rdata, 32'h0000_00AB);

    for (int i = 0; i < 20; i++) begin
      v = 32'(i * 3);
      if (i == 7) v = 32'hFFFF_FFFB;
      if (i == 12) v = 32'd100;
      do_write(32'(1000 + 4 * i), v);
    end
    run_scan("basic", 32'd100, 32'd12, 1'b0, 32'd0);

    do_write(32'd1016, 32'h7FFF_FFFF);
    do_write(32'd1036, 32'h7FFF_FFFF);
    do_write(32'd1008, 32'h8000_0000);
    run_scan("tie", 32'h7FFF_FFFF, 32'd4, 1'b0, 32'd0);

    run_scan("wr0", 32'h7FFF_FFFF, 32'd0, 1'b1, 32'h7FFF_FFFF);
    do_read(32'd1060, d);
    chk("ignored_write", d, 32'd45);
    do_read(32'd1000, d);
    chk("same_edge_write", d, 32'h7FFF_FFFF);

    scan_start = 1'b1;
    $display("scan  reset-abort start");
    step();
    idle_inputs();
    for (int k = 0; k < 9; k++) step();
    rst = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd1000;
    step();
    rst = 1'b1;
    idle_inputs();
    chkb("abort_ready", req_ready, 1'b1);
    chkb("abort_busy", scan_busy, 1'b0);
    chkb("abort_rsp", rsp_valid, 1'b0);
    chk("abort_max", max, 32'd0);
    chk("abort_index", max_index, 32'd0);
    do_read(32'd1004, d);
    chk("cleared_1004", d, 32'd0);
    do_read(32'd1048, d);
    chk("cleared_1048", d, 32'd0);
    dones = 0;
    for (int k = 0; k < SCAN_LEN + 5; k++) begin
      step();
      if (scan_done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
